// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one split read/write RAM port between two requesters.
// One transaction at a time; each access ends with a one-cycle ack, and a stalled RAM is released by a timeout.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [SEL_W-1:0]  m0_sel,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [SEL_W-1:0]  m1_sel,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram_ren,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_rvalid,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wen,
  output logic [SEL_W-1:0]  ram_sel,
  input  logic              ram_wready,
  output logic              busy,
  output logic              grant
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               prio_q, prio_d;
  logic               err_q, err_d;
  logic               grant_d, busy_d, pick;
  logic [1:0]         req_v, ack_d, aerr_d;
  logic               ren_d, wen_d;
  logic [ADDR_W-1:0]  raddr_d, waddr_d;
  logic [DATA_W-1:0]  wdata_d, rdata0_d, rdata1_d;
  logic [SEL_W-1:0]   sel_d;

  // State, RAM-side and requester-side registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prio_q    <= 1'b0;
      err_q     <= 1'b0;
      grant     <= 1'b0;
      busy      <= 1'b0;
      ram_ren   <= 1'b0;
      ram_raddr <= '0;
      ram_wen   <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      ram_sel   <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prio_q    <= prio_d;
      err_q     <= err_d;
      grant     <= grant_d;
      busy      <= busy_d;
      ram_ren   <= ren_d;
      ram_raddr <= raddr_d;
      ram_wen   <= wen_d;
      ram_waddr <= waddr_d;
      ram_wdata <= wdata_d;
      ram_sel   <= sel_d;
      m0_ack    <= ack_d[0];
      m1_ack    <= ack_d[1];
      m0_err    <= aerr_d[0];
      m1_err    <= aerr_d[1];
      m0_rdata  <= rdata0_d;
      m1_rdata  <= rdata1_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prio_d   = prio_q;
    err_d    = err_q;
    grant_d  = grant;
    ren_d    = ram_ren;
    raddr_d  = ram_raddr;
    wen_d    = ram_wen;
    waddr_d  = ram_waddr;
    wdata_d  = ram_wdata;
    sel_d    = ram_sel;
    ack_d    = 2'b00;
    aerr_d   = 2'b00;
    rdata0_d = m0_rdata;
    rdata1_d = m1_rdata;
    pick     = 1'b0;
    // A requester whose ack is on the wire this cycle is still holding its finished request
    req_v    = {m1_req & ~m1_ack, m0_req & ~m0_ack};

    unique case (state_q)
      IDLE: begin
        if (|req_v) begin
          pick    = (&req_v) ? prio_q : req_v[1];
          grant_d = pick;
          prio_d  = ~pick;
          cnt_d   = '0;
          err_d   = 1'b0;
          if (pick ? m1_we : m0_we) begin
            wen_d   = 1'b1;
            waddr_d = pick ? m1_addr  : m0_addr;
            wdata_d = pick ? m1_wdata : m0_wdata;
            sel_d   = pick ? m1_sel   : m0_sel;
            state_d = WR;
          end else begin
            ren_d   = 1'b1;
            raddr_d = pick ? m1_addr : m0_addr;
            state_d = RD;
          end
        end
      end
      RD: begin
        if (ram_rvalid) begin
          ren_d   = 1'b0;
          state_d = ACK;
          if (grant) rdata1_d = ram_rdata;
          else       rdata0_d = ram_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          ren_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ACK;
          if (grant) rdata1_d = '0;
          else       rdata0_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR: begin
        if (ram_wready) begin
          wen_d   = 1'b0;
          state_d = ACK;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          wen_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACK: begin
        ack_d[grant]  = 1'b1;
        aerr_d[grant] = err_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: reads, writes, round-robin, timeout, mid-transaction reset, stray handshakes.
module tb_ram_port_arbiter;

  logic        clk, rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] ram_raddr, ram_rdata, ram_waddr, ram_wdata;
  logic        ram_ren, ram_rvalid, ram_wen, ram_wready;
  logic [3:0]  ram_sel;
  logic        busy, grant;

  int checks = 0;
  int errors = 0;

  ram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_sel(m0_sel),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_sel(m1_sel),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .ram_raddr(ram_raddr), .ram_ren(ram_ren), .ram_rdata(ram_rdata), .ram_rvalid(ram_rvalid),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wen(ram_wen), .ram_sel(ram_sel),
    .ram_wready(ram_wready), .busy(busy), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0;
    ram_rvalid = 1'b0; ram_wready = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Single read with the RAM answering in the first ren cycle
  task automatic run_read(input bit m, input logic [31:0] addr, input logic [31:0] data);
    if (m) begin m1_req = 1'b1; m1_we = 1'b0; m1_addr = addr; end
    else   begin m0_req = 1'b1; m0_we = 1'b0; m0_addr = addr; end
    step();
    check("rd_ren", ram_ren, 1);
    check("rd_raddr", ram_raddr, addr);
    check("rd_grant", grant, m);
    ram_rvalid = 1'b1; ram_rdata = data;
    step();
    ram_rvalid = 1'b0;
    step();
    check("rd_ack", m ? m1_ack : m0_ack, 1);
    check("rd_err", m ? m1_err : m0_err, 0);
    check("rd_data", m ? m1_rdata : m0_rdata, data);
    check("rd_other_ack", m ? m0_ack : m1_ack, 0);
    m0_req = 1'b0; m1_req = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dbl;
    int seq [8];
    m0_we = 0; m1_we = 0; m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    m0_sel = 0; m1_sel = 0; ram_rdata = 0;
    do_reset();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_ren", ram_ren, 0);
    check("rst_wen", ram_wen, 0);
    check("rst_ack", {m0_ack, m1_ack}, 0);
    check("rst_rdata", m0_rdata, 0);

    // m0 read at 0x10, rvalid one cycle after ren
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    step();
    check("t1_ren", ram_ren, 1);
    check("t1_raddr", ram_raddr, 32'h10);
    check("t1_busy", busy, 1);
    ram_rvalid = 1'b1; ram_rdata = 32'hDEADBEEF;
    step();
    ram_rvalid = 1'b0;
    check("t1_ren_drop", ram_ren, 0);
    check("t1_ack_early", m0_ack, 0);
    step();
    check("t1_ack", m0_ack, 1);
    check("t1_rdata", m0_rdata, 32'hDEADBEEF);
    check("t1_err", m0_err, 0);
    check("t1_m1_ack", m1_ack, 0);
    m0_req = 1'b0;
    step();
    check("t1_ack_pulse", m0_ack, 0);
    check("t1_idle", busy, 0);

    // m1 write with 3 wait cycles; requester inputs change while granted
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h04000020; m1_wdata = 32'h12345678; m1_sel = 4'b0011;
    step();
    m1_wdata = 32'hFFFFFFFF; m1_addr = 32'h0; m1_sel = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      check("t2_wen", ram_wen, 1);
      check("t2_waddr", ram_waddr, 32'h04000020);
      check("t2_wdata", ram_wdata, 32'h12345678);
      check("t2_sel", ram_sel, 4'b0011);
      if (i == 3) ram_wready = 1'b1;
      step();
    end
    ram_wready = 1'b0;
    check("t2_wen_drop", ram_wen, 0);
    check("t2_ack_early", m1_ack, 0);
    step();
    check("t2_ack", m1_ack, 1);
    check("t2_err", m1_err, 0);
    check("t2_m0_ack", m0_ack, 0);
    check("t2_m0_rdata", m0_rdata, 32'hDEADBEEF);
    m1_req = 1'b0;
    step();
    check("t2_ack_pulse", m1_ack, 0);

    // Stray wready during RD, stray rvalid during WR
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20;
    step();
    ram_wready = 1'b1;
    step();
    ram_wready = 1'b0;
    check("t6_rd_hold", ram_ren, 1);
    ram_rvalid = 1'b1; ram_rdata = 32'h0BADF00D;
    step();
    ram_rvalid = 1'b0;
    check("t6_rd_done", ram_ren, 0);
    step();
    check("t6_rd_ack", m0_ack, 1);
    check("t6_rd_data", m0_rdata, 32'h0BADF00D);
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h30; m1_wdata = 32'h55AA55AA; m1_sel = 4'b1100;
    step();
    step();
    ram_rvalid = 1'b1;
    step();
    ram_rvalid = 1'b0;
    check("t6_wr_hold", ram_wen, 1);
    check("t6_wr_noack", m1_ack, 0);
    ram_wready = 1'b1;
    step();
    ram_wready = 1'b0;
    step();
    check("t6_wr_ack", m1_ack, 1);
    check("t6_m1_rdata", m1_rdata, 0);
    m1_req = 1'b0;
    step();

    // Continuous contention after reset: grants alternate starting with m0
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h200;
    ram_rvalid = 1'b1; ram_rdata = 32'h11;
    n = 0; dbl = 0;
    for (int c = 0; c < 24; c++) begin
      step();
      if (m0_ack && m1_ack) dbl++;
      if (n < 8 && m0_ack) begin seq[n] = 0; n++; end
      if (n < 8 && m1_ack) begin seq[n] = 1; n++; end
    end
    check("rr_double", dbl, 0);
    check("rr_enough", (n >= 4), 1);
    for (int k = 0; k < 4; k++) check("rr_seq", seq[k], k % 2);
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (4) step();
    ram_rvalid = 1'b0;
    check("rr_idle", busy, 0);

    // Read timeout with rvalid never asserted
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
    step();
    n = 0;
    while (ram_ren && n < 400) begin
      n++;
      step();
    end
    check("to_ren_cycles", n, 256);
    step();
    check("to_ack", m0_ack, 1);
    check("to_err", m0_err, 1);
    check("to_rdata", m0_rdata, 0);
    m0_req = 1'b0;
    step();
    check("to_err_pulse", m0_err, 0);
    run_read(1'b1, 32'h44, 32'hCAFE0001);

    // Reset in the middle of a stalled write
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h50; m1_wdata = 32'h1; m1_sel = 4'hF;
    step();
    step();
    check("mr_wen_pre", ram_wen, 1);
    rst = 1'b0;
    step();
    check("mr_wen", ram_wen, 0);
    check("mr_busy", busy, 0);
    check("mr_ack", m1_ack, 0);
    rst = 1'b1; m1_req = 1'b0;
    step();
    check("mr_ack_after", m1_ack, 0);
    run_read(1'b0, 32'h80, 32'hA5A5A5A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one mapped RAM port (RAM0 or RAM1 style: separate read/write channels, ren/rvalid and wen/wready handshakes) between two requesters.
- Typical pairing: m0 = tinycpu data port, m1 = debug/loader port.
- Grants are round-robin; one transaction is outstanding at a time.
- Each access completes with a single-cycle ack pulse carrying read data or an error flag; a stalled RAM is released by a timeout.

Parameters:
- ADDR_W, 32, address width for requesters and RAM.
- DATA_W, 32, data width.
- SEL_W, 4, byte-select width (DATA_W/8).
- TIMEOUT, 255, cycles to wait for rvalid/wready before aborting; 8-bit counter.

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- mN_req  in  1  request; N=0,1; held until ack
- mN_we  in  1  1=write, 0=read
- mN_addr  in  ADDR_W  byte address
- mN_wdata  in  DATA_W  write data
- mN_sel  in  SEL_W  byte lanes for write
- mN_ack  out  1  one-cycle completion pulse
- mN_err  out  1  valid with ack; 1 = timed out
- mN_rdata  out  DATA_W  read data; valid with ack
- ram_raddr  out  ADDR_W
- ram_ren  out  1
- ram_rdata  in  DATA_W
- ram_rvalid  in  1
- ram_waddr  out  ADDR_W
- ram_wdata  out  DATA_W
- ram_wen  out  1
- ram_sel  out  SEL_W
- ram_wready  in  1
- busy  out  1  state != IDLE
- grant  out  1  index of current/last granted requester

Behaviour:
- All outputs are registered.
- Reset (rst=0 at an edge):
  - state=IDLE; all ack/err/rdata, ram_* outputs, busy and grant = 0; timeout counter = 0.
  - Round-robin pointer set so m0 wins the first tie.
- Reset mid-transaction: ren/wen drop at that edge; no ack is issued.
- States: IDLE, RD, WR, ACK.
- IDLE:
  - No req: stay.
  - One req: grant it.
  - Both req: grant the one not granted last.
  - On grant: latch addr/wdata/sel/we into RAM-side registers; set grant; clear counter.
  - Go to RD (ren=1, raddr=addr) or WR (wen=1, waddr, wdata, sel).
- Latency: req sampled at the end of cycle t → ren/wen high in cycle t+1.
- RD:
  - Hold ren and raddr until ram_rvalid=1.
  - On rvalid: capture ram_rdata into the granted mN_rdata; ren←0; state←ACK; ack/err=0.
  - ram_wready is ignored in RD.
- WR:
  - Hold wen/waddr/wdata/sel until ram_wready=1.
  - On wready: wen←0; state←ACK.
  - ram_rvalid is ignored in WR.
- Timeout:
  - Counter increments each RD/WR cycle without completion.
  - When counter==TIMEOUT: ren/wen←0; mN_rdata←0; err←1; state←ACK.
- ACK:
  - Granted mN_ack=1 for exactly one cycle; mN_err as latched; then IDLE.
  - The non-granted ack is never asserted.
- Requester rule: drop req (or present the next request) on the edge at which ack is sampled high.
  - IDLE after ACK therefore never re-grants a completed request.
- Minimum round trip: req at cycle t → ack in cycle t+3, given rvalid/wready in cycle t+1.
- mN_rdata holds its value until the next read completion for that requester.
- Writes leave mN_rdata unchanged.
- Requester inputs changing while granted are ignored; the latched copies drive the RAM.
- Address passes through unchanged; no decode or alignment checks.

Test Plan:
- Reset, then m0 read addr 0x10, RAM returns rvalid one cycle after ren with 0xDEADBEEF → ren high exactly 1 cycle; m0_ack in cycle t+3; m0_rdata=0xDEADBEEF; m0_err=0; m1_ack never high.
- m1 write addr 0x04000020, wdata 0x12345678, sel 0b0011, wready after 3 wait cycles → wen/waddr/wdata/sel stable 4 cycles; m1_ack one pulse; m0_rdata unchanged.
- m0 and m1 request simultaneously and continuously, re-requesting after each ack → grants alternate 0,1,0,1 starting with m0 after reset; no double grant.
- Read with rvalid never asserted → ren drops after TIMEOUT+1 RD cycles (256); ack with err=1 and rdata=0; the next request is served normally.
- rst=0 in the middle of a WR with wready low → wen=0 and busy=0 at the next edge; no ack; a fresh read after reset completes normally.
- Stray ram_rvalid pulses during WR and ram_wready pulses during RD → ignored; completion occurs only on the matching handshake.
